// File: rtl/delta_sigma_pdm.sv
// Audio DAC back end: 16-bit PCM in, differential 1-bit PDM out.
// A free-running phase counter frames one sample every 2**OSR_LOG2 clocks.
// A linear interpolator ramps between consecutive samples. The ramp is scaled
// by 3/4 and fed to a second-order delta-sigma loop with a 1-bit quantizer.
module delta_sigma_pdm #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned OSR_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    output logic [1:0]       pdm
);

    localparam int unsigned UW  = WIDTH + 1;  // sample difference / ramp width
    localparam int unsigned I1W = 20;
    localparam int unsigned I2W = 24;
    localparam int unsigned S1W = I1W + 2;    // headroom for i1 + v - fb
    localparam int unsigned S2W = I2W + 2;    // headroom for i2 + i1 - fb

    localparam logic signed [UW-1:0]  FB_POS = UW'(2 ** (WIDTH - 1));
    localparam logic signed [UW-1:0]  FB_NEG = -FB_POS;
    localparam logic signed [S1W-1:0] I1_MAX = S1W'((2 ** (I1W - 1)) - 1);
    localparam logic signed [S1W-1:0] I1_MIN = S1W'(-(2 ** (I1W - 1)));
    localparam logic signed [S2W-1:0] I2_MAX = S2W'((2 ** (I2W - 1)) - 1);
    localparam logic signed [S2W-1:0] I2_MIN = S2W'(-(2 ** (I2W - 1)));

    logic [OSR_LOG2-1:0]     ph_q, ph_d;
    logic signed [WIDTH-1:0] prev_q, curr_q, data_s;
    logic signed [UW-1:0]    diff_q, diff_d;
    logic signed [UW-1:0]    u_q, u_d;
    logic signed [UW-1:0]    v, fb;
    logic signed [S1W-1:0]   i1_sum;
    logic signed [S2W-1:0]   i2_sum;
    logic signed [I1W-1:0]   i1_q, i1_d;
    logic signed [I2W-1:0]   i2_q, i2_d;
    logic                    y_d;
    logic [1:0]              pdm_q;
    logic                    frame_start;

    assign data_s      = $signed(data);
    assign frame_start = (ph_q == '0);

    // Frame bookkeeping: phase advance, per-frame slope and the linear ramp.
    always_comb begin
        ph_d   = ph_q + OSR_LOG2'(1);
        diff_d = diff_q;
        // Truncated slope can overshoot curr by a few LSBs; UW bits absorb it.
        u_d    = u_q + (diff_q >>> OSR_LOG2);
        if (frame_start) begin
            diff_d = UW'(data_s) - UW'(curr_q);
            u_d    = UW'(curr_q);
        end
    end

    // Second-order loop: 3/4 input scaling, saturating integrators, sign quantizer.
    always_comb begin
        v      = u_q - (u_q >>> 2);
        fb     = pdm_q[0] ? FB_POS : FB_NEG;
        i1_sum = S1W'(i1_q) + S1W'(v) - S1W'(fb);
        // Second stage integrates the pre-update i1.
        i2_sum = S2W'(i2_q) + S2W'(i1_q) - S2W'(fb);

        if (i1_sum > I1_MAX) begin
            i1_d = {1'b0, {(I1W - 1){1'b1}}};
        end else if (i1_sum < I1_MIN) begin
            i1_d = {1'b1, {(I1W - 1){1'b0}}};
        end else begin
            i1_d = i1_sum[I1W-1:0];
        end

        if (i2_sum > I2_MAX) begin
            i2_d = {1'b0, {(I2W - 1){1'b1}}};
        end else if (i2_sum < I2_MIN) begin
            i2_d = {1'b1, {(I2W - 1){1'b0}}};
        end else begin
            i2_d = i2_sum[I2W-1:0];
        end

        y_d = ~i2_d[I2W-1];
    end

    // State registers; reset parks the bridge at 00 and clears the whole pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= '0;
            prev_q <= '0;
            curr_q <= '0;
            diff_q <= '0;
            u_q    <= '0;
            i1_q   <= '0;
            i2_q   <= '0;
            pdm_q  <= 2'b00;
        end else begin
            ph_q <= ph_d;
            if (frame_start) begin
                prev_q <= curr_q;
                curr_q <= data_s;
            end
            diff_q <= diff_d;
            u_q    <= u_d;
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            // pdm_q[0] doubles as the quantizer state used for feedback.
            pdm_q  <= {~y_d, y_d};
        end
    end

    assign pdm = pdm_q;

endmodule

// File: tb/tb_delta_sigma_pdm.sv
// Bench for delta_sigma_pdm: an arithmetic model of the sample framing,
// closed-form interpolation ramp and saturating second-order loop is
// stepped alongside the DUT and compared every clock, with literal checks
// on reset behaviour, the interpolation ramp and long-run output density.
module tb_delta_sigma_pdm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [1:0]  pdm;

    int n_vec = 0;
    int n_bad = 0;

    // Model state
    int      m_ph, m_k;
    longint  m_prev, m_curr, m_diff, m_u, m_i1, m_i2;
    bit      m_y, m_run;

    // Window statistics
    int cnt_dut, cnt_mdl, run_len, max_run, sat_hits;
    bit last_bit, watch_sat;

    delta_sigma_pdm #(
        .WIDTH    (16),
        .OSR_LOG2 (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .pdm   (pdm)
    );

    always #5 clk = ~clk;

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint sat(input longint x, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input longint act,
                               input longint lo, input longint hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_k = 0;
        m_prev = 0; m_curr = 0; m_diff = 0; m_u = 0;
        m_i1 = 0; m_i2 = 0; m_y = 1'b0; m_run = 1'b0;
    endtask

    // One rising edge of the specified behaviour, in plain arithmetic.
    task automatic model_edge();
        longint v, fb, i1n, i2n;
        v   = m_u - fdiv(m_u, 4);
        fb  = m_y ? 32768 : -32768;
        i1n = sat(m_i1 + v - fb, 20);
        i2n = sat(m_i2 + m_i1 - fb, 24);
        m_i1 = i1n;
        m_i2 = i2n;
        m_y  = (i2n >= 0);
        m_run = 1'b1;
        if (m_ph == 0) begin
            m_prev = m_curr;
            m_curr = longint'($signed(data));
            m_diff = m_curr - m_prev;
            m_k    = 0;
        end else begin
            m_k++;
        end
        m_ph = (m_ph + 1) % 8;
        m_u  = m_prev + m_k * fdiv(m_diff, 8);
    endtask

    // Advance one clock, update the model, compare everything 1 time unit later.
    task automatic tick();
        longint exp_pdm;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge();
        exp_pdm = m_run ? {~m_y, m_y} : 2'b00;
        check("pdm", pdm, exp_pdm);
        check("u", longint'($signed(dut.u_q)), m_u);
        check("ph", dut.ph_q, m_ph);
        check("i1", longint'($signed(dut.i1_q)), m_i1);
        check("i2", longint'($signed(dut.i2_q)), m_i2);
        if (pdm[0] == last_bit) run_len++;
        else run_len = 1;
        last_bit = pdm[0];
        if (run_len > max_run) max_run = run_len;
        cnt_dut += pdm[0];
        cnt_mdl += m_y;
        if (watch_sat) begin
            if (dut.i1_q == 20'sh7FFFF || dut.i1_q == 20'sh80000) sat_hits++;
            if (dut.i2_q == 24'sh7FFFFF || dut.i2_q == 24'sh800000) sat_hits++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_window(input int n);
        cnt_dut = 0; cnt_mdl = 0; max_run = 0; run_len = 1; last_bit = pdm[0];
        run(n);
    endtask

    // Wait until the next edge is a sample-capture edge.
    task automatic align();
        for (int i = 0; i < 8 && m_ph != 0; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        data  = '0;
        watch_sat = 1'b0;
        sat_hits = 0;
        model_reset();
        #2;
        check("async_rst_initial", pdm, 2'b00);

        // Held in reset with a wandering input: bridge stays off.
        for (int i = 0; i < 10; i++) begin
            data = 16'($urandom);
            tick();
            check("rst_pdm_off", pdm, 2'b00);
        end
        data  = 16'd0;
        rst_n = 1'b1;
        check("ph_after_release", dut.ph_q, 0);

        // Zero input: 4-ones/4-zeros idle pattern, exactly half density.
        run(64);
        count_window(2048);
        check_range("zero_density_dut", cnt_dut, 1020, 1028);
        check_range("zero_density_model", cnt_mdl, 1020, 1028);
        check_range("zero_max_run", max_run, 1, 4);

        // Half scale: density (1 + 0.375)/2 = 0.6875.
        align();
        data = 16'h4000;
        run(256);
        count_window(2048);
        check_range("half_density_dut", cnt_dut, 1398, 1418);
        check_range("half_density_model", cnt_mdl, 1398, 1418);

        // Negative full scale: density 0.125, integrators stay off their rails.
        align();
        data = 16'h8000;
        run(256);
        watch_sat = 1'b1;
        count_window(2048);
        watch_sat = 1'b0;
        check_range("negfs_density_dut", cnt_dut, 246, 266);
        check_range("negfs_density_model", cnt_mdl, 246, 266);
        check("negfs_no_saturation", sat_hits, 0);

        // Step 0 -> 24576: ramp +3072 per clock, full value one frame later.
        align();
        data = 16'd0;
        run(64);
        align();
        data = 16'd24576;
        tick();
        check("step_u_model_k0", m_u, 0);
        check("step_u_dut_k0", longint'($signed(dut.u_q)), 0);
        for (int k = 1; k < 8; k++) begin
            tick();
            check("step_u_model", m_u, 3072 * k);
            check("step_u_dut", longint'($signed(dut.u_q)), 3072 * k);
        end
        tick();
        check("step_u_model_final", m_u, 24576);
        check("step_u_dut_final", longint'($signed(dut.u_q)), 24576);
        run(256);
        count_window(2048);
        check_range("step_density_dut", cnt_dut, 1580, 1620);
        check_range("step_density_model", cnt_mdl, 1580, 1620);

        // Mid-run reset during a +16384 stream.
        align();
        data = 16'h4000;
        run(128);
        rst_n = 1'b0;
        #1;
        check("midrun_async_off", pdm, 2'b00);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrun_rst_pdm_off", pdm, 2'b00);
        end
        rst_n = 1'b1;
        check("midrun_ph_zero", dut.ph_q, 0);
        tick();
        check("midrun_ph_first_edge", dut.ph_q, 1);
        run(64);
        count_window(2048);
        check_range("midrun_density_dut", cnt_dut, 1398, 1418);
        check_range("midrun_density_model", cnt_mdl, 1398, 1418);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
